// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR coefficient loader.
package fir_pkg;

  localparam int NTAPS  = 64;
  localparam int COEF_W = 16;
  localparam int IDX_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_READY  = 2'd2
  } state_t;

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file: one synchronous write port, one combinational read port,
// asynchronously cleared to zero.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int DEPTH = NTAPS,
  parameter int WIDTH = COEF_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_flat;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          entry_q <= '0;
        end else if (we_i && (waddr_i == IDX_W'(gi))) begin
          entry_q <= wdata_i;
        end
      end

      assign mem_flat[gi] = entry_q;
    end
  endgenerate

  assign rdata_o = mem_flat[raddr_i];

endmodule

// File: rtl/fir_coef_loader.sv
// Streams a host-written coefficient bank to the filter core, one tap per clk2 cycle,
// then holds b_valid until the next load request.
module fir_coef_loader #(
  parameter int NTAPS  = fir_pkg::NTAPS,
  parameter int COEF_W = fir_pkg::COEF_W
) (
  input  logic                      clk2,
  input  logic                      ALU_restn,
  input  logic                      wr_en,
  input  logic [fir_pkg::IDX_W-1:0] wr_addr,
  input  logic [COEF_W-1:0]         wr_data,
  input  logic                      start,
  output logic [COEF_W-1:0]         b,
  output logic                      b_valid,
  output logic                      busy,
  output logic [fir_pkg::IDX_W-1:0] coef_idx,
  output logic                      wr_err
);

  import fir_pkg::IDX_W;
  import fir_pkg::state_t;
  import fir_pkg::ST_IDLE;
  import fir_pkg::ST_STREAM;
  import fir_pkg::ST_READY;

  localparam logic [IDX_W:0]   NTAPS_EXT = (IDX_W + 1)'(NTAPS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NTAPS - 1);

  state_t            state_q, state_d;
  logic [COEF_W-1:0] b_q, b_d, rd_data;
  logic [IDX_W-1:0]  idx_q, idx_d, rd_addr;
  logic              b_valid_q, b_valid_d;
  logic              busy_q, busy_d;
  logic              wr_err_q, wr_err_d;
  logic              armed_q, wr_req, start_req, addr_ok, bank_we, idx_last;

  // The first edge after reset release is not allowed to accept commands.
  always_ff @(posedge clk2 or negedge ALU_restn) begin
    if (!ALU_restn) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  assign wr_req    = wr_en & armed_q;
  assign start_req = start & armed_q;
  assign addr_ok   = {1'b0, wr_addr} < NTAPS_EXT;
  assign bank_we   = wr_req & addr_ok & (state_q != ST_STREAM);
  assign idx_last  = (idx_q == LAST_IDX);
  // Read one tap ahead so the registered b lines up with the registered coef_idx.
  assign rd_addr   = ((state_q == ST_STREAM) && !idx_last) ? idx_q + 1'b1 : '0;

  fir_coef_bank #(
    .DEPTH (NTAPS),
    .WIDTH (COEF_W)
  ) u_bank (
    .clk_i   (clk2),
    .rst_ni  (ALU_restn),
    .we_i    (bank_we),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    b_d       = '0;
    idx_d     = '0;
    b_valid_d = b_valid_q;
    busy_d    = 1'b0;
    wr_err_d  = wr_req & ~(addr_ok & (state_q != ST_STREAM));

    unique case (state_q)
      ST_IDLE, ST_READY: begin
        if (start_req) begin
          state_d   = ST_STREAM;
          busy_d    = 1'b1;
          b_valid_d = 1'b0;
          // A same-cycle write to tap 0 must already be in the streamed set.
          b_d       = (bank_we && (wr_addr == '0)) ? wr_data : rd_data;
        end
      end
      ST_STREAM: begin
        if (idx_last) begin
          state_d   = ST_READY;
          b_valid_d = 1'b1;
        end else begin
          idx_d     = idx_q + 1'b1;
          b_d       = rd_data;
          busy_d    = 1'b1;
          b_valid_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        b_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk2 or negedge ALU_restn) begin
    if (!ALU_restn) begin
      state_q   <= ST_IDLE;
      b_q       <= '0;
      idx_q     <= '0;
      b_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      b_valid_q <= b_valid_d;
      busy_q    <= busy_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign b        = b_q;
  assign b_valid  = b_valid_q;
  assign busy     = busy_q;
  assign coef_idx = idx_q;
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Scoreboard bench for fir_coef_loader: stimulus pushes expected taps/events, a monitor pops them.
module tb_fir_coef_loader;

  localparam int NTAPS  = 64;
  localparam int COEF_W = 16;

  logic              clk2 = 1'b0;
  logic              ALU_restn = 1'b1;
  logic              wr_en = 1'b0;
  logic [5:0]        wr_addr = '0;
  logic [COEF_W-1:0] wr_data = '0;
  logic              start = 1'b0;
  logic [COEF_W-1:0] b;
  logic              b_valid, busy, wr_err;
  logic [5:0]        coef_idx;

  fir_coef_loader #(
    .NTAPS  (NTAPS),
    .COEF_W (COEF_W)
  ) dut (
    .clk2      (clk2),
    .ALU_restn (ALU_restn),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .b         (b),
    .b_valid   (b_valid),
    .busy      (busy),
    .coef_idx  (coef_idx),
    .wr_err    (wr_err)
  );

  initial forever #5 clk2 = ~clk2;

  int cyc = 0;
  always @(posedge clk2) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [5:0]        idx;
    logic [COEF_W-1:0] b;
  } exp_t;

  exp_t              stream_q[$];
  int                valid_q[$];
  int                err_q[$];
  logic [COEF_W-1:0] model_bank[NTAPS];
  int                s_edge = -1000;
  int                checks = 0;
  int                errors = 0;
  bit                mon_en = 1'b0;
  bit                prev_valid = 1'b0;
  exp_t              ex;

  // Reference: state at edge e is "streaming" for the 64 edges after the accepting edge.
  function automatic bit in_stream(input int e);
    return (e >= s_edge + 1) && (e <= s_edge + NTAPS);
  endfunction

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input bit we, input logic [5:0] a, input logic [COEF_W-1:0] d, input bit st);
    int e;
    e = cyc + 1;
    wr_en   = we;
    wr_addr = a;
    wr_data = d;
    start   = st;
    if (we) begin
      if (in_stream(e) || int'(a) >= NTAPS) begin
        err_q.push_back(e);
        $display("write tap %0d <= %h at edge %0d: expect rejection", a, d, e);
      end else begin
        model_bank[a] = d;
      end
    end
    if (st && !in_stream(e)) begin
      s_edge = e;
      for (int k = 0; k < NTAPS; k++) begin
        stream_q.push_back('{cyc: e + k, idx: 6'(k), b: model_bank[k]});
      end
      valid_q.push_back(e + NTAPS);
      $display("start accepted at edge %0d: %0d taps, b_valid due at %0d", e, NTAPS, e + NTAPS);
    end
    tick();
    wr_en = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((stream_q.size() != 0 || valid_q.size() != 0 || err_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (stream_q.size() != 0 || valid_q.size() != 0 || err_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending taps=%0d valid=%0d err=%0d, expected all 0",
               stream_q.size(), valid_q.size(), err_q.size());
      stream_q.delete();
      valid_q.delete();
      err_q.delete();
    end
    tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_b"}, 32'(b), 32'h0);
    chk({tag, "_b_valid"}, 32'(b_valid), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_coef_idx"}, 32'(coef_idx), 32'h0);
    chk({tag, "_wr_err"}, 32'(wr_err), 32'h0);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < NTAPS; k++) drive(1'b1, 6'(k), COEF_W'(k + 1), 1'b0);
  endtask

  // Monitor: every output cycle is checked against the scoreboard queues.
  always @(negedge clk2) begin
    if (!mon_en) begin
      prev_valid = 1'b0;
    end else begin
      checks++;
      if (busy === 1'b1) begin
        if (stream_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: busy at cyc %0d idx=%0d b=%h, expected idle", cyc, coef_idx, b);
        end else begin
          ex = stream_q.pop_front();
          if (b !== ex.b || coef_idx !== ex.idx || cyc != ex.cyc || b_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_tap: cyc %0d got b=%h idx=%0d valid=%b, expected b=%h idx=%0d valid=0 at cyc %0d",
                     cyc, b, coef_idx, b_valid, ex.b, ex.idx, ex.cyc);
          end
        end
      end else if (busy !== 1'b0 || b !== '0 || coef_idx !== '0) begin
        errors++;
        $display("FAIL idle_outputs: cyc %0d got busy=%b b=%h idx=%0d, expected busy=0 b=0 idx=0",
                 cyc, busy, b, coef_idx);
      end
      if (b_valid === 1'b1 && !prev_valid) begin
        checks++;
        if (valid_q.size() == 0 || valid_q[0] != cyc) begin
          errors++;
          $display("FAIL b_valid_rise: rose at cyc %0d, expected cyc %0d",
                   cyc, (valid_q.size() != 0) ? valid_q[0] : -1);
        end
        if (valid_q.size() != 0) void'(valid_q.pop_front());
      end
      if (prev_valid && b_valid !== 1'b1 && busy !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL b_valid_drop: fell at cyc %0d with busy=%b, expected busy=1", cyc, busy);
      end
      if (wr_err === 1'b1) begin
        checks++;
        if (err_q.size() == 0 || err_q[0] != cyc) begin
          errors++;
          $display("FAIL wr_err_pulse: pulse at cyc %0d, expected cyc %0d",
                   cyc, (err_q.size() != 0) ? err_q[0] : -1);
        end
        if (err_q.size() != 0) void'(err_q.pop_front());
      end
      prev_valid = (b_valid === 1'b1);
    end
  end

  initial begin
    int e;
    for (int k = 0; k < NTAPS; k++) model_bank[k] = '0;

    #3 ALU_restn = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(posedge clk2);

    // Commands coincident with the reset-release edge must be ignored.
    @(negedge clk2);
    start = 1'b1; wr_en = 1'b1; wr_addr = 6'd3; wr_data = 16'h5555;
    #4 ALU_restn = 1'b1;
    tick();
    start = 1'b0; wr_en = 1'b0;
    mon_en = 1'b1;
    repeat (3) tick();

    drive(1'b0, '0, '0, 1'b1);          // cleared bank streams zeros
    drain();

    load_ramp();                        // 0x0001..0x0040
    drive(1'b0, '0, '0, 1'b1);
    drain();

    drive(1'b1, 6'd5, 16'h8000, 1'b0);
    drive(1'b1, 6'd63, 16'hFFFF, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    drain();

    e = cyc + 1;                        // start from READY, then a write and a start mid-stream
    drive(1'b0, '0, '0, 1'b1);
    wait_until(e + 10);
    drive(1'b1, 6'd10, 16'h1234, 1'b0);
    wait_until(e + 20);
    drive(1'b0, '0, '0, 1'b1);
    drain();
    drive(1'b0, '0, '0, 1'b1);          // identical second stream
    drain();

    e = cyc + 1;                        // reset while tap 30 is on b
    drive(1'b0, '0, '0, 1'b1);
    wait_until(e + 30);
    @(negedge clk2);
    #2 ALU_restn = 1'b0;
    mon_en = 1'b0;
    #1 check_zero("midstream_reset");
    stream_q.delete(); valid_q.delete(); err_q.delete();
    s_edge = -1000;
    for (int k = 0; k < NTAPS; k++) model_bank[k] = '0;
    @(negedge clk2);
    #2 ALU_restn = 1'b1;
    tick();
    mon_en = 1'b1;
    repeat (3) tick();

    drive(1'b1, 6'd0, 16'h7FFF, 1'b1); // write and start together from IDLE
    drain();
    load_ramp();
    drive(1'b0, '0, '0, 1'b1);
    drain();

    for (int i = 0; i < 800; i++) begin
      bit                we, st;
      logic [5:0]        a;
      logic [COEF_W-1:0] d;
      we = ($urandom_range(0, 99) < 25);
      st = ($urandom_range(0, 99) < 4);
      a  = 6'($urandom_range(0, NTAPS - 1));
      d  = COEF_W'($urandom);
      drive(we, a, d, st);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
